// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port req/ack arbiter and asynchronous-SRAM cycle
// sequencer for the cellular RAM. Port 0 is the read-only sample fetcher,
// port 1 the read/write loader path. One access is in flight at a time:
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES clocks) -> RECOVER -> IDLE.
// Compile-time option: define PSRAM_ARB_RR_EN for round-robin arbitration;
// left undefined, arbitration is fixed priority with port 0 first.
module psram_arbiter #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dq_o,
    output logic              mem_dq_oe,
    input  logic [DATA_W-1:0] mem_dq_i,
    output logic              ram_cs_n,
    output logic              mem_oe_n,
    output logic              mem_wr_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n,
    output logic              ram_adv_n,
    output logic              ram_clk
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    // ACCESS lasts WAIT_CYCLES clocks; the counter runs 0 .. WAIT_CYCLES-1
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              owner;      // 0 = port 0, 1 = port 1
    logic              we_r;
    logic [DATA_W-1:0] wdata_r;
    logic              grant_any;
    logic              grant_p1;
    logic              grant_now;
    logic              last_access;

    assign grant_any   = p0_req | p1_req;
    assign grant_now   = (state == IDLE) && grant_any;
    assign last_access = (cnt == CNT_LAST);

    // Async mode: no burst clock, address-valid tied active
    assign ram_adv_n = 1'b0;
    assign ram_clk   = 1'b0;
    assign mem_dq_o  = wdata_r;

`ifdef PSRAM_ARB_RR_EN
    logic last_owner;

    // Remember who won the last grant so contention alternates between ports
    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= 1'b1;
        else if (grant_now)
            last_owner <= grant_p1;
    end

    assign grant_p1 = p1_req & (~p0_req | ~last_owner);
`else
    // Fixed priority: port 1 only wins when port 0 is not asking
    assign grant_p1 = p1_req & ~p0_req;
`endif

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and strobe decode; strobes are a pure function of state
    always_comb begin
        state_nxt = state;
        ram_cs_n  = 1'b1;
        mem_oe_n  = 1'b1;
        mem_wr_n  = 1'b1;
        ram_lb_n  = 1'b1;
        ram_ub_n  = 1'b1;
        mem_dq_oe = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any)
                    state_nxt = SETUP;
            end
            SETUP: begin
                ram_cs_n  = 1'b0;
                ram_lb_n  = 1'b0;
                ram_ub_n  = 1'b0;
                mem_dq_oe = we_r;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                ram_cs_n  = 1'b0;
                ram_lb_n  = 1'b0;
                ram_ub_n  = 1'b0;
                mem_oe_n  = we_r;
                mem_wr_n  = ~we_r;
                mem_dq_oe = we_r;
                if (last_access)
                    state_nxt = RECOVER;
            end
            RECOVER: begin
                // Keep driving write data past the WE# rising edge
                mem_dq_oe = we_r;
                p0_ack    = ~owner;
                p1_ack    = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latch, access counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b0;
            we_r     <= 1'b0;
            wdata_r  <= '0;
            mem_adr  <= '0;
            cnt      <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            if (grant_now) begin
                owner   <= grant_p1;
                we_r    <= grant_p1 & p1_we;
                mem_adr <= grant_p1 ? p1_addr : p0_addr;
                if (grant_p1 && p1_we)
                    wdata_r <= p1_wdata;
            end
            if (state == SETUP)
                cnt <= '0;
            else if (state == ACCESS)
                cnt <= cnt + 4'd1;
            if ((state == ACCESS) && last_access && !we_r) begin
                if (owner)
                    p1_rdata <= mem_dq_i;
                else
                    p0_rdata <= mem_dq_i;
            end
        end
    end

endmodule
